multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_outdec.sv | 83 ++++++++
 rtl/multicycle_ctrl.sv | 118 +++++++++++
 tb/tb_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct fields,
// ALUOp codes, datapath select codes and the control vector.
package multicycle_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_DECODE   = 4'd2;
    localparam state_t ST_EXEC_R   = 4'd3;
    localparam state_t ST_EXEC_I   = 4'd4;
    localparam state_t ST_WB_R     = 4'd5;
    localparam state_t ST_WB_I     = 4'd6;
    localparam state_t ST_MEM_ADDR = 4'd7;
    localparam state_t ST_MEM_RD   = 4'd8;
    localparam state_t ST_MEM_WR   = 4'd9;
    localparam state_t ST_WB_MEM   = 4'd10;
    localparam state_t ST_BRANCH   = 4'd11;
    localparam state_t ST_JUMP     = 4'd12;
    localparam state_t ST_NOP      = 4'd13;
    localparam state_t ST_TRAP     = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    // Unsupported encodings map to ST_NOP; the top may redirect that to ST_TRAP.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        nxt = ST_NOP;
        case (op)
            OP_RTYPE: if (fn == FN_ADD || fn == FN_SLT) nxt = ST_EXEC_R;
            OP_ADDI:  nxt = ST_EXEC_I;
            OP_LW,
            OP_SW:    nxt = ST_MEM_ADDR;
            OP_BEQ:   nxt = ST_BRANCH;
            OP_J:     nxt = ST_JUMP;
            default:  nxt = ST_NOP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational map from the registered FSM state (plus funct and mem_ready) to the
// datapath control vector.
module multicycle_ctrl_outdec
    import multicycle_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.pc_src    = PC_ALU;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_NOP:  ctrl.instr_done = 1'b1;
            ST_TRAP: ctrl.trap       = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: state/hold registers and retired counter; outputs via outdec.
// MULTICYCLE_CTRL_TRAP_EN: unsupported encodings trap instead of retiring as NOP.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned RST_PC_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             trap
);

    localparam logic [3:0] HOLD_LAST = 4'(RST_PC_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctrl;
    logic [5:0]       opcode, funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_FETCH;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_FETCH: if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                state_d = decode_target(opcode, funct);
`ifdef MULTICYCLE_CTRL_TRAP_EN
                if (state_d == ST_NOP) state_d = ST_TRAP;
`endif
            end
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_NOP: state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (ctrl.instr_done) retired_q <= retired_q + CNT_W'(1);
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .state     (state_q),
        .funct     (funct),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_src        = ctrl.pc_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign instr_done    = ctrl.instr_done;
    assign retired       = retired_q;

    // alu_zero is consumed by the datapath together with pc_write_cond.
    logic unused_bits;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap        = ctrl.trap;
    assign unused_bits = ^{instr[25:6], alu_zero};
`else
    assign trap        = 1'b0;
    assign unused_bits = ^{instr[25:6], alu_zero, ctrl.trap};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected retirements, a monitor
// checks latency, retired count and control outputs on every instr_done.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src, alu_src_b;
    logic        alu_src_a;
    logic [2:0]  alu_op;
    logic        reg_write, reg_dst, mem_to_reg, instr_done, trap;
    logic [31:0] retired;

    multicycle_ctrl #(.CNT_W(32), .RST_PC_HOLD(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .alu_zero      (alu_zero),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .instr_done    (instr_done),
        .retired       (retired),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          ret;
        logic [14:0] vec;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   fetch_waits = 0;
    int   data_waits = 0;
    int   exp_ret = 0;

    // {reg_write, reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_src, alu_src_a,
    //  alu_src_b, alu_op, mem_we, ir_write}
    function automatic logic [14:0] mk(input logic rw, input logic rd, input logic mtr,
                                       input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic we, input logic irw);
        return {rw, rd, mtr, pcw, pcwc, pcs, asa, asb, aop, we, irw};
    endfunction

    function automatic logic [14:0] obs();
        return {reg_write, reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_src, alu_src_a,
                alu_src_b, alu_op, mem_we, ir_write};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic expect_done(input string name, input int lat, input logic [14:0] vec);
        exp_t e;
        e.lat  = lat;
        e.ret  = exp_ret;
        e.vec  = vec;
        e.name = name;
        sb.push_back(e);
        exp_ret++;
    endtask

    // Steps until instr_done; counts data-request cycles and captures the rs-side ALU op.
    task automatic wait_done(input string name, output int dreq, output logic [2:0] exec_op);
        bit got;
        got     = 1'b0;
        dreq    = 0;
        exec_op = 3'b111;
        for (int k = 0; k < 60 && !got; k++) begin
            step();
            if (mem_req && i_or_d) dreq++;
            if (alu_src_a) exec_op = alu_op;
            if (instr_done) got = 1'b1;
        end
        if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Memory model: answers each request after the configured number of wait cycles.
    int wait_left = 0;
    bit busy = 1'b0;
    always @(negedge clk) begin
        if (!mem_req) begin
            busy      = 1'b0;
            mem_ready = 1'b0;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = i_or_d ? data_waits : fetch_waits;
            end
            if (wait_left == 0) begin
                mem_ready = 1'b1;
                busy      = 1'b0;
            end else begin
                mem_ready = 1'b0;
                wait_left--;
            end
        end
    end

    // Monitor: latency measured from the first FETCH cycle to the instr_done cycle.
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_fetch = 1'b0;
    initial begin
        logic fetch_now;
        exp_t e;
        forever begin
            step();
            cyc++;
            fetch_now = mem_req && !i_or_d;
            if (fetch_now && !prev_fetch) start_cyc = cyc;
            prev_fetch = fetch_now;
            if (instr_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_latency"}, 64'(cyc - start_cyc + 1), 64'(e.lat));
                    check({e.name, "_retired"}, 64'(retired), 64'(e.ret));
                    check({e.name, "_ctrl"}, 64'(obs()), 64'(e.vec));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [14:0] V_WB_R   = 15'b1_1_0_0_0_00_0_00_000_0_0;
    localparam logic [14:0] V_WB_I   = 15'b1_0_0_0_0_00_0_00_000_0_0;
    localparam logic [14:0] V_WB_MEM = 15'b1_0_1_0_0_00_0_00_000_0_0;
    localparam logic [14:0] V_MEM_WR = 15'b0_0_0_0_0_00_0_00_000_1_0;
    localparam logic [14:0] V_BRANCH = 15'b0_0_0_0_1_01_1_00_110_0_0;
    localparam logic [14:0] V_JUMP   = 15'b0_0_0_1_0_10_0_00_000_0_0;

    initial begin
        int          dreq;
        logic [2:0]  xop;
        logic [14:0] v;
        int          cnt;
        bit          seen;

        v = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        check("vec_encoding", 64'(v), 64'(V_WB_R));

        rst = 1'b1;
        repeat (3) step();
        check("reset_outputs", 64'({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                                    pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                                    mem_to_reg, instr_done, trap}), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);

        // add: one IDLE cycle after release, then FETCH/DECODE/EXEC_R/WB_R
        instr = 32'h012A4020;
        expect_done("add", 4, V_WB_R);
        rst = 1'b0;
        step();
        check("first_fetch", 64'({mem_req, i_or_d, ir_write, pc_write}), 64'b1011);
        wait_done("add", dreq, xop);
        check("add_alu_op", 64'(xop), 64'b000);

        instr = 32'h21280005;  // addi, one fetch wait state
        fetch_waits = 1;
        expect_done("addi", 5, V_WB_I);
        wait_done("addi", dreq, xop);
        fetch_waits = 0;

        instr = 32'h012A402A;  // slt
        expect_done("slt", 4, V_WB_R);
        wait_done("slt", dreq, xop);
        check("slt_alu_op", 64'(xop), 64'b100);

        instr = 32'h8D090004;  // lw, two data wait states
        data_waits = 2;
        expect_done("lw", 7, V_WB_MEM);
        wait_done("lw", dreq, xop);
        check("lw_req_cycles", 64'(dreq), 64'd3);
        data_waits = 0;

        instr = 32'hAD090004;  // sw
        expect_done("sw", 4, V_MEM_WR);
        wait_done("sw", dreq, xop);
        check("sw_req_cycles", 64'(dreq), 64'd1);

        instr = 32'h11090003;  // beq taken
        alu_zero = 1'b1;
        expect_done("beq_z1", 3, V_BRANCH);
        wait_done("beq_z1", dreq, xop);
        check("beq_z1_alu_op", 64'(xop), 64'b110);
        alu_zero = 1'b0;       // beq not taken: same control
        expect_done("beq_z0", 3, V_BRANCH);
        wait_done("beq_z0", dreq, xop);
        check("beq_z0_alu_op", 64'(xop), 64'b110);

        instr = 32'h08000010;  // j
        expect_done("j", 3, V_JUMP);
        wait_done("j", dreq, xop);
        step();
        check("j_then_fetch", 64'({mem_req, i_or_d}), 64'b10);
        check("retired_after_j", 64'(retired), 64'(exp_ret));

        instr = 32'hFC000000;  // unsupported opcode
`ifdef MULTICYCLE_CTRL_TRAP_EN
        step();
        step();
        check("trap_set", 64'(trap), 64'd1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mem_req) cnt++;
        end
        check("trap_no_mem_req", 64'(cnt), 64'd0);
        check("trap_held", 64'(trap), 64'd1);
`else
        expect_done("nop", 3, 15'd0);
        wait_done("nop", dreq, xop);
        check("nop_trap_low", 64'(trap), 64'd0);
        step();
        check("nop_retired", 64'(retired), 64'(exp_ret));
`endif

        // clean reset, retire one add, then abandon a stalled sw
        rst = 1'b1;
        step();
        check("trap_cleared", 64'(trap), 64'd0);
        exp_ret = 0;
        instr = 32'h012A4020;
        expect_done("add2", 4, V_WB_R);
        rst = 1'b0;
        wait_done("add2", dreq, xop);

        instr = 32'hAD090004;
        data_waits = 5;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (mem_req && i_or_d && mem_we) seen = 1'b1;
        end
        check("sw_reached_mem_wr", 64'(seen), 64'd1);
        check("retired_before_abort", 64'(retired), 64'd1);
        rst = 1'b1;
        step();
        exp_ret = 0;
        check("abort_mem_req", 64'(mem_req), 64'd0);
        check("abort_retired", 64'(retired), 64'd0);
        data_waits = 0;

        instr = 32'h21280005;
        expect_done("addi2", 4, V_WB_I);
        rst = 1'b0;
        wait_done("addi2", dreq, xop);
        step();
        check("final_retired", 64'(retired), 64'(exp_ret));
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
